// File: rtl/uart_rx_frame.sv
// uart_rx_frame
//   Receives one UART frame at a time from an oversampled serial line:
//   start(0), 8 data bits LSB first, optional parity bit, stop(1).
//   Every bit is decided by a 3-sample majority vote around mid-bit.
//
// Parameters
//   PRESCALE   clocks per bit (8, 16 or 32)
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous, active-high reset
//   RX_IN      serial line, idle high, already synchronous to clk
//   Par_EN     1: a parity bit follows the data (captured at start detect)
//   Par_TYP    0: even parity, 1: odd parity (captured at start detect)
//   P_DATA     last good byte, updated only on a good frame
//   Data_Valid one-cycle pulse, good frame
//   Par_err    one-cycle pulse, parity mismatch
//   Stop_err   one-cycle pulse, stop bit voted 0
//   busy       high whenever the receiver is not idle
//
// Frame timing, with the start-detect cycle counted as cycle 0 and
// N = PRESCALE * (10 + Par_EN):
//   busy is high on cycles 1..N-1, the result pulse is on cycle N-1 and
//   the receiver is idle again on cycle N, where it can already detect the
//   next start bit.
module uart_rx_frame #(
  parameter int PRESCALE = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RX_IN,
  input  logic       Par_EN,
  input  logic       Par_TYP,
  output logic [7:0] P_DATA,
  output logic       Data_Valid,
  output logic       Par_err,
  output logic       Stop_err,
  output logic       busy
);

  localparam int EW = $clog2(PRESCALE);
  localparam int M  = PRESCALE / 2;

  // Edge-counter positions of interest inside one bit period.
  localparam logic [EW-1:0] E_S0   = EW'(M - 1);        // first sample
  localparam logic [EW-1:0] E_S1   = EW'(M);            // second sample
  localparam logic [EW-1:0] E_VOTE = EW'(M + 1);        // third sample + decision
  localparam logic [EW-1:0] E_OUT  = EW'(PRESCALE - 2); // load result flags
  localparam logic [EW-1:0] E_LAST = EW'(PRESCALE - 1); // last clock of the bit

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t        state;
  logic [EW-1:0] ecnt;       // clock position inside the current bit
  logic [2:0]    bcnt;       // data bit index
  logic          s0, s1;     // first two samples of the vote
  logic [7:0]    shreg;      // data bits collected so far
  logic          f_par_en;   // frame copy of Par_EN
  logic          f_par_typ;  // frame copy of Par_TYP
  logic          par_bad;    // parity bit disagreed with the data
  logic          stop_bit;   // voted value of the stop bit
  logic          vote;       // majority of s0, s1 and the live sample

  // The third sample is taken straight off the line on the decision cycle,
  // so the vote is available on the same edge that consumes it.
  always_comb begin
    vote = (s0 & s1) | (s0 & RX_IN) | (s1 & RX_IN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ecnt       <= '0;
      bcnt       <= '0;
      s0         <= 1'b1;
      s1         <= 1'b1;
      shreg      <= '0;
      f_par_en   <= 1'b0;
      f_par_typ  <= 1'b0;
      par_bad    <= 1'b0;
      stop_bit   <= 1'b1;
      P_DATA     <= '0;
      Data_Valid <= 1'b0;
      Par_err    <= 1'b0;
      Stop_err   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      // Result flags are single-cycle pulses.
      Data_Valid <= 1'b0;
      Par_err    <= 1'b0;
      Stop_err   <= 1'b0;

      if (state == IDLE) begin
        // The detect cycle is ecnt = 0 of the start bit, so the bit timer
        // continues at 1. Frame options are frozen here for the whole frame.
        if (!RX_IN) begin
          state     <= START;
          ecnt      <= EW'(1);
          bcnt      <= '0;
          f_par_en  <= Par_EN;
          f_par_typ <= Par_TYP;
          par_bad   <= 1'b0;
          busy      <= 1'b1;
        end
      end else begin
        ecnt <= (ecnt == E_LAST) ? '0 : ecnt + EW'(1);

        if (ecnt == E_S0) s0 <= RX_IN;
        if (ecnt == E_S1) s1 <= RX_IN;

        case (state)
          START: begin
            // A start bit that votes high was only a glitch on the line.
            if (ecnt == E_VOTE && vote) begin
              state <= IDLE;
              ecnt  <= '0;
              busy  <= 1'b0;
            end else if (ecnt == E_LAST) begin
              state <= DATA;
            end
          end

          DATA: begin
            if (ecnt == E_VOTE) shreg[bcnt] <= vote;
            if (ecnt == E_LAST) begin
              bcnt <= bcnt + 3'd1;
              if (bcnt == 3'd7) state <= f_par_en ? PARITY : STOP;
            end
          end

          PARITY: begin
            // Received parity bit must equal XOR(data) ^ Par_TYP.
            if (ecnt == E_VOTE) par_bad <= vote ^ (^shreg) ^ f_par_typ;
            if (ecnt == E_LAST) state <= STOP;
          end

          STOP: begin
            if (ecnt == E_VOTE) stop_bit <= vote;
            // Flags are loaded one clock early so the pulse sits on the final
            // clock of the frame, the same clock that hands back to IDLE.
            if (ecnt == E_OUT) begin
              if (!stop_bit) begin
                Stop_err <= 1'b1;
              end else if (par_bad) begin
                Par_err <= 1'b1;
              end else begin
                P_DATA     <= shreg;
                Data_Valid <= 1'b1;
              end
            end
            if (ecnt == E_LAST) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end

          default: begin
            state <= IDLE;
            ecnt  <= '0;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_frame.sv
module tb_uart_rx_frame;
  localparam int P = 8;
  localparam int M = P / 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx_in = 1'b1;
  logic       par_en = 1'b0;
  logic       par_typ = 1'b0;
  logic [7:0] p_data;
  logic       data_valid, par_err, stop_err, busy;

  uart_rx_frame #(.PRESCALE(P)) dut (
    .clk       (clk),
    .rst       (rst),
    .RX_IN     (rx_in),
    .Par_EN    (par_en),
    .Par_TYP   (par_typ),
    .P_DATA    (p_data),
    .Data_Valid(data_valid),
    .Par_err   (par_err),
    .Stop_err  (stop_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // Per-cycle stimulus: line level and the option inputs for that cycle.
  bit          line_q[$];
  bit          pen_q[$];
  bit          typ_q[$];
  // Per-cycle observation/expectation: {busy, Stop_err, Par_err, Data_Valid, P_DATA}
  logic [11:0] rec[$];
  logic [11:0] expv[$];
  logic [7:0]  mdata;    // model's idea of P_DATA

  task automatic clear_line();
    line_q.delete(); pen_q.delete(); typ_q.delete();
  endtask

  task automatic push_cycle(bit v, bit pen, bit typ);
    line_q.push_back(v); pen_q.push_back(pen); typ_q.push_back(typ);
  endtask

  task automatic add_idle(int n);
    repeat (n) push_cycle(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  task automatic add_low(int n);
    repeat (n) push_cycle(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  // One frame of P cycles per bit. Options are only meaningful on the
  // start-detect cycle; elsewhere they are scrambled on purpose.
  // glitch >= 0 forces a single low sample at mid-bit of that data bit.
  task automatic add_frame(logic [7:0] d, bit pen, bit ptyp, bit bad_par, bit bad_stop, int glitch);
    bit bits[$];
    bit v;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (pen) bits.push_back(1'((^d) ^ ptyp ^ bad_par));
    bits.push_back(!bad_stop);
    foreach (bits[b]) begin
      for (int e = 0; e < P; e++) begin
        v = bits[b];
        if (glitch >= 0 && b == glitch + 1 && e == M) v = 1'b0;
        if (b == 0 && e == 0) push_cycle(v, pen, ptyp);
        else push_cycle(v, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
    end
  endtask

  // Drive line_q cycle by cycle; rec[c] holds the outputs seen during cycle c,
  // and line_q[c] is what the DUT samples at the end of cycle c.
  task automatic run_line();
    rec.delete();
    foreach (line_q[c]) begin
      @(posedge clk); #1;
      rx_in = line_q[c]; par_en = pen_q[c]; par_typ = typ_q[c];
      @(negedge clk);
      rec.push_back({busy, stop_err, par_err, data_valid, p_data});
    end
  endtask

  function automatic bit line_at(int k);
    if (k >= 0 && k < line_q.size()) return line_q[k];
    return 1'b1;
  endfunction

  // Majority of three consecutive line samples starting at cycle k.
  function automatic bit vote3(int k);
    bit a, b, c;
    a = line_at(k); b = line_at(k + 1); c = line_at(k + 2);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Reference receiver: scans the recorded line from an idle state and
  // predicts per-cycle busy / pulses / P_DATA from the framing rules.
  task automatic build_expect();
    int         L, t, n, e;
    bit         fpen, ftyp, pb, sb;
    logic [7:0] d, cur;
    bit         dv[], pe[], se[], bz[];
    logic [7:0] nd[];
    L = line_q.size();
    dv = new[L]; pe = new[L]; se = new[L]; bz = new[L]; nd = new[L];
    foreach (nd[i]) nd[i] = 8'h00;
    t = 0;
    while (t < L) begin
      if (line_q[t]) begin
        t++;
        continue;
      end
      fpen = pen_q[t]; ftyp = typ_q[t];
      n = P * (10 + int'(fpen));
      if (vote3(t + M - 1)) begin
        for (int c = t + 1; c <= t + M + 1 && c < L; c++) bz[c] = 1'b1;
        t = t + M + 2;
        continue;
      end
      for (int i = 0; i < 8; i++) d[i] = vote3(t + (1 + i) * P + M - 1);
      pb = fpen && (vote3(t + 9 * P + M - 1) != ((^d) ^ ftyp));
      sb = vote3(t + (9 + int'(fpen)) * P + M - 1);
      for (int c = t + 1; c < t + n && c < L; c++) bz[c] = 1'b1;
      e = t + n - 1;
      if (e < L) begin
        if (!sb) se[e] = 1'b1;
        else if (pb) pe[e] = 1'b1;
        else begin dv[e] = 1'b1; nd[e] = d; end
      end
      t = t + n;
    end
    expv.delete();
    cur = mdata;
    for (int c = 0; c < L; c++) begin
      if (dv[c]) cur = nd[c];
      expv.push_back({bz[c], se[c], pe[c], dv[c], cur});
    end
    mdata = cur;
  endtask

  task automatic test_reset();
    rst = 1'b1; rx_in = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, stop_err, par_err, data_valid, p_data} !== 12'h000)
      $display("FAIL reset_outputs: got %h want 000", {busy, stop_err, par_err, data_valid, p_data});
    else passed++;
    @(posedge clk); #1; rst = 1'b0;
    mdata = 8'h00;
  endtask

  task automatic test_basic();
    int s;
    clear_line(); add_idle(3); s = 3;
    add_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, -1); add_idle(4);
    run_line(); build_expect();
    foreach (expv[c]) begin
      checks++;
      if (rec[c] !== expv[c]) $display("FAIL basic_cycle%0d: got %h want %h", c, rec[c], expv[c]);
      else passed++;
    end
    checks++;
    if (rec[s + 79] !== 12'h9A5) $display("FAIL basic_dv79: got %h want 9a5", rec[s + 79]);
    else passed++;
    checks++;
    if (rec[s + 80][11] !== 1'b0) $display("FAIL basic_busy80: got %b want 0", rec[s + 80][11]);
    else passed++;
    checks++;
    if (rec[s + 1][11] !== 1'b1) $display("FAIL basic_busy1: got %b want 1", rec[s + 1][11]);
    else passed++;
  endtask

  task automatic test_parity();
    int s1, s2;
    clear_line(); add_idle(2); s1 = 2;
    add_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, -1); add_idle(2);
    s2 = s1 + 88 + 2;
    add_frame(8'h3C, 1'b1, 1'b1, 1'b1, 1'b0, -1); add_idle(3);
    run_line(); build_expect();
    foreach (expv[c]) begin
      checks++;
      if (rec[c] !== expv[c]) $display("FAIL parity_cycle%0d: got %h want %h", c, rec[c], expv[c]);
      else passed++;
    end
    checks++;
    if (rec[s1 + 87] !== 12'h93C) $display("FAIL parity_even_dv87: got %h want 93c", rec[s1 + 87]);
    else passed++;
    checks++;
    if (rec[s2 + 87] !== 12'hA3C) $display("FAIL parity_odd_err87: got %h want a3c", rec[s2 + 87]);
    else passed++;
  endtask

  task automatic test_stop_err();
    int s;
    logic [7:0] old;
    old = mdata;
    clear_line(); add_idle(2); s = 2;
    add_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b1, -1); add_idle(3);
    run_line(); build_expect();
    foreach (expv[c]) begin
      checks++;
      if (rec[c] !== expv[c]) $display("FAIL stop_cycle%0d: got %h want %h", c, rec[c], expv[c]);
      else passed++;
    end
    checks++;
    if (rec[s + 79] !== {4'b1100, old}) $display("FAIL stop_err79: got %h want %h", rec[s + 79], {4'b1100, old});
    else passed++;
  endtask

  task automatic test_start_glitch();
    int s;
    clear_line(); add_idle(2); s = 2;
    add_low(2); add_idle(20);
    run_line(); build_expect();
    foreach (expv[c]) begin
      checks++;
      if (rec[c] !== expv[c]) $display("FAIL glitch_cycle%0d: got %h want %h", c, rec[c], expv[c]);
      else passed++;
    end
    checks++;
    if (rec[s + 5][11] !== 1'b1) $display("FAIL glitch_busy5: got %b want 1", rec[s + 5][11]);
    else passed++;
    checks++;
    if (rec[s + 6][11:8] !== 4'b0000) $display("FAIL glitch_idle6: got %b want 0000", rec[s + 6][11:8]);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int s;
    clear_line(); add_idle(2); s = 2;
    add_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    add_frame(8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, 5);
    add_idle(3);
    run_line(); build_expect();
    foreach (expv[c]) begin
      checks++;
      if (rec[c] !== expv[c]) $display("FAIL b2b_cycle%0d: got %h want %h", c, rec[c], expv[c]);
      else passed++;
    end
    checks++;
    if (rec[s + 79] !== 12'h955) $display("FAIL b2b_first79: got %h want 955", rec[s + 79]);
    else passed++;
    checks++;
    if (rec[s + 159] !== 12'h9F0) $display("FAIL b2b_second159: got %h want 9f0", rec[s + 159]);
    else passed++;
    checks++;
    if (rec[s + 80][11] !== 1'b0) $display("FAIL b2b_idle80: got %b want 0", rec[s + 80][11]);
    else passed++;
  endtask

  task automatic test_mid_reset();
    int s;
    clear_line();
    add_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    for (int c = 0; c <= 40; c++) begin
      @(posedge clk); #1;
      rx_in = line_q[c]; par_en = pen_q[c]; par_typ = typ_q[c];
      rst = (c == 40);
    end
    @(posedge clk); #1;
    rst = 1'b0; rx_in = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, stop_err, par_err, data_valid, p_data} !== 12'h000)
      $display("FAIL midrst_outputs: got %h want 000", {busy, stop_err, par_err, data_valid, p_data});
    else passed++;
    mdata = 8'h00;
    clear_line(); add_idle(2); s = 2;
    add_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, -1); add_idle(3);
    run_line(); build_expect();
    foreach (expv[c]) begin
      checks++;
      if (rec[c] !== expv[c]) $display("FAIL midrst_cycle%0d: got %h want %h", c, rec[c], expv[c]);
      else passed++;
    end
    checks++;
    if (rec[s + 79] !== 12'h93C) $display("FAIL midrst_dv79: got %h want 93c", rec[s + 79]);
    else passed++;
  endtask

  task automatic test_random();
    logic [7:0] d;
    bit pen, ptyp, bp, bs;
    int g;
    for (int sc = 0; sc < 6; sc++) begin
      clear_line(); add_idle($urandom_range(1, 3));
      for (int f = 0; f < 4; f++) begin
        d = 8'($urandom); pen = 1'($urandom_range(0, 1)); ptyp = 1'($urandom_range(0, 1));
        bp = ($urandom_range(0, 3) == 0); bs = ($urandom_range(0, 5) == 0);
        g = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 7)) : -1;
        add_frame(d, pen, ptyp, bp, bs, g);
        if ($urandom_range(0, 3) == 0) add_idle($urandom_range(0, 2));
        else if ($urandom_range(0, 4) == 0) begin
          add_low($urandom_range(1, 2)); add_idle(M + 2);
        end
      end
      add_idle(3);
      run_line(); build_expect();
      foreach (expv[c]) begin
        checks++;
        if (rec[c] !== expv[c]) $display("FAIL random%0d_cycle%0d: got %h want %h", sc, c, rec[c], expv[c]);
        else passed++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_stop_err();
    test_start_glitch();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no completion want completion");
    $fatal(1, "watchdog");
  end

endmodule
